// File: rtl/pkt_evt_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pkt_evt_monitor
// Description : Pipeline tap placed directly upstream of databus. Forwards the
//               packet stream unchanged through one register stage and turns
//               every sampled, completed packet into one 64-bit event word
//               that is written into the databus payload FIFO.
//
//               Event word layout:
//                 [63:32] tag       sequence number or cycle timestamp
//                 [31:24] src_port  from the IO-queue module header
//                 [23:16] flags     bit 0 = events were lost before this one
//                 [15:0]  byte_len  from the IO-queue module header
//
// Ports       : clk            single clock
//               reset          synchronous, active-low (0 = reset)
//               in_data/ctrl/wr  upstream packet stream
//               in_rdy         combinational copy of out_rdy
//               out_data/ctrl/wr registered copy of the accepted stream
//               out_rdy        downstream ready
//               enable         0 = no events generated (forwarding continues)
//               pld_fifo_din   event word to payload FIFO
//               pld_fifo_wr    one-cycle write strobe per event
//               pld_fifo_full  payload FIFO full
//               evt_count      events written to FIFO, wraps at 2**32
//               drop_count     events lost to backpressure, saturating
//
// Build option: PKT_EVT_TIMESTAMP_EN
//               defined   -> tag is a free-running cycle counter sampled on
//                            the completing word
//               undefined -> tag is the sequence number of built events
//                            (dropped events included, so gaps show losses)
//
// Revision    : 1.0  initial release
// ============================================================================
module pkt_evt_monitor #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    CTRL_WIDTH  = 8,
    parameter int                    WORD_WIDTH  = 64,
    parameter int                    SAMPLE_LOG2 = 0,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL    = CTRL_WIDTH'('hFF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  enable,
    output logic [WORD_WIDTH-1:0] pld_fifo_din,
    output logic                  pld_fifo_wr,
    input  logic                  pld_fifo_full,
    output logic [31:0]           evt_count,
    output logic [31:0]           drop_count
);

    // Packet framing state
    localparam logic [0:0] c_ST_HDR = 1'b0;  // waiting for first data word
    localparam logic [0:0] c_ST_PKT = 1'b1;  // inside packet body

    logic [0:0]            r_state;
    logic [15:0]           r_byte_len;
    logic [7:0]            r_src_port;

    logic                  r_pend_valid;
    logic [WORD_WIDTH-1:0] r_pend_word;
    logic                  r_drop_flag;
    logic [31:0]           r_evt_count;
    logic [31:0]           r_drop_count;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_sample_hit;
    logic                  w_build;
    logic                  w_drain;
    logic                  w_load;
    logic                  w_drop;
    logic [31:0]           w_tag;
    logic [WORD_WIDTH-1:0] w_event;

    // ------------------------------------------------------------------
    // Forwarding path: never stalls on the payload FIFO
    // ------------------------------------------------------------------
    assign in_rdy   = out_rdy;
    assign w_accept = in_wr & out_rdy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data <= '0;
            out_ctrl <= '0;
            out_wr   <= 1'b0;
        end else begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
            out_wr   <= w_accept;
        end
    end

    // ------------------------------------------------------------------
    // Packet framing. Only accepted words move the state. While waiting
    // for the body, the IO-queue header refreshes length/port; any other
    // non-zero ctrl word (other module headers) is skipped. If no IO-queue
    // header arrives, the values of the previous packet are reused.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_ST_HDR;
            r_byte_len <= '0;
            r_src_port <= '0;
        end else if (w_accept) begin
            case (r_state)
                c_ST_HDR: begin
                    if (in_ctrl == IOQ_CTRL) begin
                        r_byte_len <= in_data[15:0];
                        r_src_port <= in_data[23:16];
                    end else if (in_ctrl == '0) begin
                        r_state <= c_ST_PKT;
                    end
                end
                c_ST_PKT: begin
                    if (in_ctrl != '0) begin
                        r_state <= c_ST_HDR;
                    end
                end
                default: r_state <= c_ST_HDR;
            endcase
        end
    end

    // The non-zero ctrl word inside the body is the last word of the packet
    assign w_complete = w_accept & (r_state == c_ST_PKT) & (in_ctrl != '0);

    // ------------------------------------------------------------------
    // Sampling: one event per 2**SAMPLE_LOG2 completed packets, counted
    // only while enabled. The first packet of each group is the one sampled.
    // ------------------------------------------------------------------
    generate
        if (SAMPLE_LOG2 > 0) begin : g_sample_div
            logic [SAMPLE_LOG2-1:0] r_sample_cnt;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_sample_cnt <= '0;
                end else if (w_complete & enable) begin
                    r_sample_cnt <= r_sample_cnt + SAMPLE_LOG2'(1);
                end
            end

            assign w_sample_hit = (r_sample_cnt == '0);
        end else begin : g_sample_all
            assign w_sample_hit = 1'b1;
        end
    endgenerate

    assign w_build = w_complete & enable & w_sample_hit;

    // ------------------------------------------------------------------
    // Event tag source
    // ------------------------------------------------------------------
`ifdef PKT_EVT_TIMESTAMP_EN
    logic [31:0] r_ts;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    assign w_tag = r_ts;
`else
    logic [31:0] r_seq;

    // Advances on every built event, including ones later dropped, so the
    // consumer sees a gap in the sequence wherever an event was lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_seq <= '0;
        end else if (w_build) begin
            r_seq <= r_seq + 32'd1;
        end
    end

    assign w_tag = r_seq;
`endif

    // flags[0] carries the loss indication current when the event is built
    assign w_event = {w_tag, r_src_port, 7'b0, r_drop_flag, r_byte_len};

    // ------------------------------------------------------------------
    // One-entry pending buffer in front of the payload FIFO. The write
    // strobe is combinational on the FIFO full flag so a full FIFO is
    // never written. A drain frees the slot in the same cycle, so an
    // event built while draining is kept rather than dropped.
    // ------------------------------------------------------------------
    assign w_drain = r_pend_valid & ~pld_fifo_full;
    assign w_load  = w_build & (~r_pend_valid | w_drain);
    assign w_drop  = w_build & r_pend_valid & ~w_drain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend_valid <= 1'b0;
            r_pend_word  <= '0;
            r_drop_flag  <= 1'b0;
            r_evt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_load) begin
                r_pend_valid <= 1'b1;
                r_pend_word  <= w_event;
            end else if (w_drain) begin
                r_pend_valid <= 1'b0;
            end

            if (w_drain) begin
                r_evt_count <= r_evt_count + 32'd1;
            end

            // A drop and a drain are mutually exclusive by construction
            if (w_drop) begin
                r_drop_flag <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 32'd1;
                end
            end else if (w_drain) begin
                r_drop_flag <= 1'b0;
            end
        end
    end

    assign pld_fifo_wr  = w_drain;
    assign pld_fifo_din = r_pend_word;
    assign evt_count    = r_evt_count;
    assign drop_count   = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_pkt_evt_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pkt_evt_monitor
// Description : Self-checking bench for pkt_evt_monitor. A reference model
//               built from packet-level rules (completed-packet counting,
//               a queue for the pending slot) is compared every cycle,
//               alongside a directed vector table and corner sequences.
//               A second instance with SAMPLE_LOG2=2 shares the inputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pkt_evt_monitor;

    localparam logic [7:0] c_IOQ = 8'hFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        out_rdy;
    logic        enable;
    logic        pld_fifo_full;

    logic        in_rdy, out_wr, pld_fifo_wr;
    logic [63:0] out_data, pld_fifo_din;
    logic [7:0]  out_ctrl;
    logic [31:0] evt_count, drop_count;

    logic        in_rdy2, out_wr2, pld_fifo_wr2;
    logic [63:0] out_data2, pld_fifo_din2;
    logic [7:0]  out_ctrl2;
    logic [31:0] evt_count2, drop_count2;

    always #5 clk = ~clk;

    pkt_evt_monitor #(.SAMPLE_LOG2(0)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .enable(enable),
        .pld_fifo_din(pld_fifo_din), .pld_fifo_wr(pld_fifo_wr), .pld_fifo_full(pld_fifo_full),
        .evt_count(evt_count), .drop_count(drop_count)
    );

    pkt_evt_monitor #(.SAMPLE_LOG2(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy2),
        .out_data(out_data2), .out_ctrl(out_ctrl2), .out_wr(out_wr2), .out_rdy(out_rdy),
        .enable(enable),
        .pld_fifo_din(pld_fifo_din2), .pld_fifo_wr(pld_fifo_wr2), .pld_fifo_full(pld_fifo_full),
        .evt_count(evt_count2), .drop_count(drop_count2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model state (post-edge view) -------------
    logic [63:0]  m_pend[$];      // at most one entry: the pending event
    int unsigned  m_evt, m_drop, m_seq, m_ts;
    bit           m_dflag, m_in_pkt;
    longint       m_ncomp;        // enabled completions since reset
    logic [15:0]  m_len;
    logic [7:0]   m_src;
    logic [63:0]  m_out_data;
    logic [7:0]   m_out_ctrl;
    bit           m_out_wr;

    // ---------------- values sampled in the current cycle ----------------
    logic         s_wr, s_owr;
    logic [63:0]  s_din, s_odata;
    logic [31:0]  s_evt, s_drop;
    logic [31:0]  wtags[$];       // tags of words written by dut
    logic [63:0]  q2[$];          // words written by dut2

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_evt = 0; m_drop = 0; m_seq = 0; m_ts = 0;
        m_dflag = 0; m_in_pkt = 0; m_ncomp = 0;
        m_len = '0; m_src = '0;
        m_out_data = '0; m_out_ctrl = '0; m_out_wr = 0;
    endtask

    task automatic model_edge(input logic [7:0] c, input logic [63:0] d, input bit wr,
                              input bit full, input bit en, input bit rdy);
        bit          accept, complete, dflag_old;
        logic [31:0] tag;
        logic [63:0] ev;
        accept    = wr && rdy;
        dflag_old = m_dflag;
`ifdef PKT_EVT_TIMESTAMP_EN
        tag = m_ts;
`else
        tag = m_seq;
`endif
        m_ts++;
        m_out_data = d; m_out_ctrl = c; m_out_wr = accept;
        if (m_pend.size() > 0 && !full) begin
            void'(m_pend.pop_front());
            m_evt++;
            m_dflag = 0;
        end
        complete = accept && m_in_pkt && (c != 8'h00);
        ev = {tag, m_src, 7'b0, dflag_old, m_len};
        if (accept) begin
            if (!m_in_pkt) begin
                if (c == c_IOQ) begin
                    m_len = d[15:0];
                    m_src = d[23:16];
                end else if (c == 8'h00) begin
                    m_in_pkt = 1;
                end
            end else if (c != 8'h00) begin
                m_in_pkt = 0;
            end
        end
        if (complete && en) begin
            if (m_ncomp % 1 == 0) begin   // SAMPLE_LOG2=0: every packet sampled
                if (m_pend.size() == 0) m_pend.push_back(ev);
                else begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                    m_dflag = 1;
                end
                m_seq++;
            end
            m_ncomp++;
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, then let the edge happen
    task automatic step(input logic [7:0] c, input logic [63:0] d, input bit wr,
                        input bit full, input bit en, input bit rdy, input bit rst_n);
        bit exp_wr;
        @(negedge clk);
        in_ctrl = c; in_data = d; in_wr = wr; pld_fifo_full = full;
        enable = en; out_rdy = rdy; reset = rst_n;
        #1;
        s_wr = pld_fifo_wr; s_din = pld_fifo_din; s_evt = evt_count;
        s_drop = drop_count; s_owr = out_wr; s_odata = out_data;
        exp_wr = (m_pend.size() > 0) && !full;
        chk("in_rdy",     in_rdy,     rdy);
        chk("out_data",   out_data,   m_out_data);
        chk("out_ctrl",   out_ctrl,   m_out_ctrl);
        chk("out_wr",     out_wr,     m_out_wr);
        chk("evt_count",  evt_count,  m_evt);
        chk("drop_count", drop_count, m_drop);
        chk("fifo_wr",    pld_fifo_wr, exp_wr);
        if (exp_wr) chk("fifo_din", pld_fifo_din, m_pend[0]);
        chk("dut2_stream", {out_wr2, in_rdy2, out_ctrl2, out_data2},
                           {out_wr, in_rdy, out_ctrl, out_data});
        if (pld_fifo_wr)  wtags.push_back(pld_fifo_din[63:32]);
        if (pld_fifo_wr2) q2.push_back(pld_fifo_din2);
        if (!rst_n) model_reset();
        else        model_edge(c, d, wr, full, en, rdy);
        @(posedge clk);
    endtask

    task automatic idle(input bit full);
        step(8'h00, 64'h0, 0, full, 1, 1, 1);
    endtask

    task automatic do_reset();
        step(8'h00, 64'h0, 0, 0, 1, 1, 0);
    endtask

    // Two-word packet without header: reuses previous length/port
    task automatic short_pkt(input bit full, input bit en);
        step(8'h00, 64'hDEAD_0000_0000_0001, 1, full, en, 1, 1);
        step(8'h01, 64'hDEAD_0000_0000_0002, 1, full, en, 1, 1);
    endtask

    typedef struct {
        logic [7:0]  ctrl;
        logic [63:0] data;
        bit          wr;
        bit          full;
        bit          exp_wr;
        logic [31:0] exp_lo;
        int unsigned exp_evt;
        int unsigned exp_drop;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int wr_cnt;
        int unsigned evt_before, drop_before;
        logic [7:0] ctrl_pick[6];

        // Basic packet, then a FIFO-full episode with drops whose recovery
        // coincides with the next completion (that event inherits the loss flag)
        tbl[0]  = '{8'hFF, 64'h0000_0000_0003_0040, 1, 0, 0, 32'h0,          0, 0};
        tbl[1]  = '{8'h00, 64'hA0A0_0000_0000_0001, 1, 0, 0, 32'h0,          0, 0};
        tbl[2]  = '{8'h00, 64'hA0A0_0000_0000_0002, 1, 0, 0, 32'h0,          0, 0};
        tbl[3]  = '{8'h01, 64'hA0A0_0000_0000_0003, 1, 0, 0, 32'h0,          0, 0};
        tbl[4]  = '{8'h00, 64'h0,                   0, 0, 1, 32'h0300_0040,  0, 0};
        tbl[5]  = '{8'h00, 64'h0,                   0, 0, 0, 32'h0,          1, 0};
        tbl[6]  = '{8'h00, 64'hB0B0_0000_0000_0001, 1, 1, 0, 32'h0,          1, 0};
        tbl[7]  = '{8'h01, 64'hB0B0_0000_0000_0002, 1, 1, 0, 32'h0,          1, 0};
        tbl[8]  = '{8'h00, 64'hB0B0_0000_0000_0003, 1, 1, 0, 32'h0,          1, 0};
        tbl[9]  = '{8'h01, 64'hB0B0_0000_0000_0004, 1, 1, 0, 32'h0,          1, 0};
        tbl[10] = '{8'h00, 64'hB0B0_0000_0000_0005, 1, 1, 0, 32'h0,          1, 1};
        tbl[11] = '{8'h01, 64'hB0B0_0000_0000_0006, 1, 1, 0, 32'h0,          1, 1};
        tbl[12] = '{8'h00, 64'hB0B0_0000_0000_0007, 1, 1, 0, 32'h0,          1, 2};
        tbl[13] = '{8'h01, 64'hB0B0_0000_0000_0008, 1, 0, 1, 32'h0300_0040,  1, 2};
        tbl[14] = '{8'h00, 64'h0,                   0, 0, 1, 32'h0301_0040,  2, 2};
        tbl[15] = '{8'h00, 64'h0,                   0, 0, 0, 32'h0,          3, 2};

        ctrl_pick = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h3C};

        model_reset();
        in_ctrl = '0; in_data = '0; in_wr = 0; pld_fifo_full = 0;
        enable = 1; out_rdy = 1; reset = 0;

        // ---------------- reset state ----------------
        do_reset();
        do_reset();
        idle(0);
        chk("rst_out_wr",  s_owr,  0);
        chk("rst_out_data", s_odata, 0);
        chk("rst_fifo_wr", s_wr,   0);
        chk("rst_fifo_din", s_din, 0);
        chk("rst_evt",     s_evt,  0);
        chk("rst_drop",    s_drop, 0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].ctrl, tbl[i].data, tbl[i].wr, tbl[i].full, 1, 1, 1);
            chk($sformatf("tbl%0d_wr", i),   s_wr,   tbl[i].exp_wr);
            chk($sformatf("tbl%0d_evt", i),  s_evt,  tbl[i].exp_evt);
            chk($sformatf("tbl%0d_drop", i), s_drop, tbl[i].exp_drop);
            if (tbl[i].exp_wr) chk($sformatf("tbl%0d_din_lo", i), s_din[31:0], tbl[i].exp_lo);
        end

        // ---------------- tags with the second packet dropped ----------------
        do_reset();
        wtags.delete();
        short_pkt(1, 1);       // tag 0, held pending
        short_pkt(1, 1);       // dropped
        idle(0);               // tag 0 written
        short_pkt(0, 1);
        idle(0);
        idle(0);
        chk("tag_writes", wtags.size(), 2);
        if (wtags.size() == 2) begin
`ifdef PKT_EVT_TIMESTAMP_EN
            chk("tag_increasing", wtags[1] > wtags[0], 1);
`else
            chk("tag_first",  wtags[0], 0);
            chk("tag_second", wtags[1], 2);
`endif
        end

        // ---------------- enable=0: stream continues, no events ----------------
        evt_before  = evt_count;
        drop_before = drop_count;
        wr_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            step(c_IOQ, 64'h0000_0000_0007_0100 + 64'(p), 1, 0, 0, 1, 1);
            if (s_wr) wr_cnt++;
            step(8'h00, 64'h1234_5678_0000_0000 + 64'(p), 1, 0, 0, 1, 1);
            if (s_wr) wr_cnt++;
            step(8'h02, 64'h8765_4321_0000_0000 + 64'(p), 1, 0, 0, 1, 1);
            if (s_wr) wr_cnt++;
        end
        idle(0);
        if (s_wr) wr_cnt++;
        idle(0);
        if (s_wr) wr_cnt++;
        chk("dis_writes", wr_cnt, 0);
        chk("dis_evt",  s_evt,  evt_before);
        chk("dis_drop", s_drop, drop_before);

        // ---------------- reset mid-packet with an event pending ----------------
        short_pkt(1, 1);                                  // event stuck pending
        step(8'h00, 64'hCAFE_0000_0000_0001, 1, 1, 1, 1, 1);  // mid-packet
        step(8'h00, 64'hCAFE_0000_0000_0002, 1, 0, 1, 1, 0);  // reset asserted
        idle(0);
        chk("mrst_fifo_wr", s_wr,  0);
        chk("mrst_out_wr",  s_owr, 0);
        chk("mrst_out_data", s_odata, 0);
        chk("mrst_evt",     s_evt, 0);
        chk("mrst_drop",    s_drop, 0);
        step(c_IOQ, 64'h0000_0000_0005_0080, 1, 0, 1, 1, 1);
        step(8'h00, 64'h0000_0000_0000_0011, 1, 0, 1, 1, 1);
        step(8'h01, 64'h0000_0000_0000_0022, 1, 0, 1, 1, 1);
        idle(0);
        chk("mrst_pkt_wr", s_wr, 1);
        chk("mrst_pkt_din_lo", s_din[31:0], 32'h0500_0080);
        idle(0);
        chk("mrst_pkt_evt", s_evt, 1);

        // ---------------- SAMPLE_LOG2=2: 8 packets -> packets 1 and 5 ----------------
        do_reset();
        q2.delete();
        for (int p = 0; p < 8; p++) begin
            step(c_IOQ, 64'(100 + p) | 64'h0000_0000_0009_0000, 1, 0, 1, 1, 1);
            step(8'h00, 64'hF00D_0000_0000_0000, 1, 0, 1, 1, 1);
            step(8'h01, 64'hF00D_0000_0000_0001, 1, 0, 1, 1, 1);
        end
        idle(0);
        idle(0);
        chk("samp_writes", q2.size(), 2);
        if (q2.size() == 2) begin
            chk("samp_first_len",  q2[0][15:0], 16'd100);
            chk("samp_second_len", q2[1][15:0], 16'd104);
        end
        chk("samp_evt2",  evt_count2,  2);
        chk("samp_drop2", drop_count2, 0);

        // ---------------- randomized traffic against the model ----------------
        for (int n = 0; n < 3000; n++) begin
            step(ctrl_pick[$urandom_range(0, 5)], {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 199) != 0);
        end
        idle(0);
        idle(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
